// File: rtl/alu_op_sequencer.sv
// Control-side sequencer for the 6502 ALU: accepts one op per valid/ready request, drives the ALU
// enables/operands for SETTLE_CYC cycles, then registers result and masked N/V/Z/C flags.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  output logic       SUM_en,
  output logic       AND_en,
  output logic       EOR_en,
  output logic       OR_en,
  output logic       ASL_en,
  output logic       LSR_en,
  output logic       INV_en,
  output logic       ROL_en,
  output logic       ROR_en,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_res,
  output logic [3:0] rsp_flags,
  output logic [3:0] rsp_mask,
  output logic       rsp_wb,
  output logic       rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;
  typedef enum logic [3:0] {
    OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2, OP_ORA = 4'd3, OP_EOR = 4'd4,
    OP_ASL = 4'd5, OP_LSR = 4'd6, OP_ROL = 4'd7, OP_ROR = 4'd8, OP_CMP = 4'd9,
    OP_BIT = 4'd10, OP_INC = 4'd11, OP_DEC = 4'd12
  } op_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  res_q, res_d;
  logic [3:0]  flags_q, flags_d, mask_q, mask_d;
  logic        wb_q, wb_d, err_q, err_d;

  // Decoded view of the latched op; order {SUM,AND,EOR,OR,ASL,LSR,INV,ROL,ROR}
  logic [8:0]  dec_en;
  logic [7:0]  dec_b;
  logic        dec_cin, dec_wb, dec_bit;
  logic [3:0]  dec_mask;
  logic [8:0]  en;
  logic        n_f, v_f, z_f, c_f;

  always_comb begin
    dec_en   = '0;
    dec_b    = b_q;
    dec_cin  = 1'b0;
    dec_mask = 4'b0000;
    dec_wb   = 1'b1;
    dec_bit  = 1'b0;
    case (op_q)
      OP_ADC: begin dec_en = 9'b100000000; dec_cin = c_q; dec_mask = 4'b1111; end
      OP_SBC: begin dec_en = 9'b100000100; dec_cin = c_q; dec_mask = 4'b1111; end
      OP_AND: begin dec_en = 9'b010000000; dec_mask = 4'b1010; end
      OP_ORA: begin dec_en = 9'b000100000; dec_mask = 4'b1010; end
      OP_EOR: begin dec_en = 9'b001000000; dec_mask = 4'b1010; end
      OP_ASL: begin dec_en = 9'b000010000; dec_cin = c_q; dec_mask = 4'b1011; end
      OP_LSR: begin dec_en = 9'b000001000; dec_cin = c_q; dec_mask = 4'b1011; end
      OP_ROL: begin dec_en = 9'b000000010; dec_cin = c_q; dec_mask = 4'b1011; end
      OP_ROR: begin dec_en = 9'b000000001; dec_cin = c_q; dec_mask = 4'b1011; end
      OP_CMP: begin dec_en = 9'b100000100; dec_cin = 1'b1; dec_mask = 4'b1011; dec_wb = 1'b0; end
      OP_BIT: begin dec_en = 9'b010000000; dec_mask = 4'b1110; dec_wb = 1'b0; dec_bit = 1'b1; end
      OP_INC: begin dec_en = 9'b100000000; dec_b = 8'h00; dec_cin = 1'b1; dec_mask = 4'b1010; end
      OP_DEC: begin dec_en = 9'b100000000; dec_b = 8'hFF; dec_cin = 1'b0; dec_mask = 4'b1010; end
      default: ;
    endcase
  end

  // BIT takes N/V straight from the memory operand rather than from the ALU
  assign n_f = dec_bit ? b_q[7] : alu_res[7];
  assign v_f = dec_bit ? b_q[6] : alu_ovf;
  assign z_f = (alu_res == 8'h00);
  assign c_f = alu_cout;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    mask_d    = mask_q;
    wb_d      = wb_q;
    err_d     = err_q;
    en        = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          c_d   = req_c;
          cnt_d = '0;
          if (req_op <= OP_DEC) begin
            state_d = S_DRIVE;
          end else begin
            res_d   = '0;
            flags_d = '0;
            mask_d  = '0;
            wb_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_DRIVE: begin
        en      = dec_en;
        alu_a   = a_q;
        alu_b   = dec_b;
        alu_cin = dec_cin;
        if (cnt_q == 4'(SETTLE_CYC - 1)) begin
          res_d   = alu_res;
          flags_d = {n_f, v_f, z_f, c_f} & dec_mask;
          mask_d  = dec_mask;
          wb_d    = dec_wb;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en} = en;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign rsp_mask  = mask_q;
  assign rsp_wb    = wb_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

endmodule
